multicycle_microprocessor: RTL and testbench

Parametrised multi-cycle successor to the 8-bit single-cycle core: same 8-bit, 2-bit-opcode ISA and 4-entry register file, with generic data width, PC width and data-memory depth. It fetches instructions through a valid/request handshake, sequences each instruction through an explicit state machine, and traps on infinite loops. It drives the PC, the writeback bus, two 7-segment digits and sticky status flags, and sits at top level between the instruction ROM and the board display.

---
 rtl/multicycle_microprocessor_if.sv | 13 +
 rtl/multicycle_microprocessor.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_microprocessor.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_microprocessor_if.sv
// Instruction fetch bus between the core and the instruction ROM.
// The core drives pc/instr_req; the ROM answers with instruction/instr_valid.
interface multicycle_microprocessor_if #(
    parameter int PC_W = 8
);
    logic [7:0]      instruction;
    logic            instr_valid;
    logic            instr_req;
    logic [PC_W-1:0] pc;

    modport master (input instruction, input instr_valid, output instr_req, output pc);
    modport slave  (output instruction, output instr_valid, input instr_req, input pc);
endinterface

// File: rtl/multicycle_microprocessor.sv
// Multi-cycle 8-bit-ISA core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer, 4-entry regfile, DMEM.
// Define MP_OVF_TRAP_EN to halt (without writeback) on signed ADD overflow.
module multicycle_microprocessor #(
    parameter int DATA_W     = 8,
    parameter int PC_W       = 8,
    parameter int DMEM_DEPTH = 16,
    parameter logic [DMEM_DEPTH*DATA_W-1:0] DMEM_INIT = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    multicycle_microprocessor_if.master imem,
    output logic                       wb_valid,
    output logic [DATA_W-1:0]          wb_data,
    output logic [6:0]                 lowerHex,
    output logic [6:0]                 higherHex,
    output logic [1:0]                 flags,
    output logic                       halted
);
    localparam int AW = $clog2(DMEM_DEPTH);
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;
    logic [DATA_W-1:0]   opa_q, opa_d, opb_q, opb_d, alu_q, alu_d, mdr_q, mdr_d;
    logic [1:0]          flags_q, flags_d;
    logic                instr_req_q, instr_req_d;
    logic                wb_valid_q;
    logic [DATA_W-1:0]   wb_data_q;
    logic [6:0]          lo_hex_q, hi_hex_q;
    logic [DATA_W-1:0]   regs_q [4];
    logic [DATA_W-1:0]   dmem_q [DMEM_DEPTH];

    logic                rf_we, dm_we;
    logic [1:0]          rf_waddr;
    logic [DATA_W-1:0]   rf_wdata, sum, imm_x;
    logic [PC_W-1:0]     imm_pc;
    logic [AW-1:0]       dm_addr;
    logic                ovf;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign imm_x   = {{(DATA_W-2){ir_q[1]}}, ir_q[1:0]};
    assign imm_pc  = {{(PC_W-2){ir_q[1]}}, ir_q[1:0]};
    assign sum     = opa_q + opb_q;
    assign ovf     = (opa_q[DATA_W-1] == opb_q[DATA_W-1]) && (sum[DATA_W-1] != opa_q[DATA_W-1]);
    assign dm_addr = AW'(opa_q + imm_x);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        alu_d       = alu_q;
        mdr_d       = mdr_q;
        flags_d     = flags_q;
        instr_req_d = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = ir_q[1:0];
        rf_wdata    = alu_q;
        dm_we       = 1'b0;
        case (state_q)
            S_FETCH: begin
                instr_req_d = 1'b1;
                if (instr_req_q && imem.instr_valid) begin
                    ir_d        = imem.instruction;
                    instr_req_d = 1'b0;
                    state_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                opa_d   = regs_q[ir_q[5:4]];
                opb_d   = regs_q[ir_q[3:2]];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (ir_q[7:6])
                    OP_ADD: begin
                        alu_d   = sum;
                        state_d = S_WB;
                        if (ovf) begin
                            flags_d[1] = 1'b1;
`ifdef MP_OVF_TRAP_EN
                            state_d = S_HALT;
`endif
                        end
                    end
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    default: begin
                        // A taken branch to itself can never make progress: trap instead.
                        if (opa_q == opb_q && ir_q[1:0] == 2'b00) begin
                            flags_d[0] = 1'b1;
                            state_d    = S_HALT;
                        end else begin
                            pc_d        = (opa_q == opb_q) ? pc_q + imm_pc : pc_q + PC_W'(1);
                            instr_req_d = 1'b1;
                            state_d     = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEM: begin
                if (ir_q[7:6] == OP_LOAD) begin
                    mdr_d   = dmem_q[dm_addr];
                    state_d = S_WB;
                end else begin
                    dm_we       = 1'b1;
                    pc_d        = pc_q + PC_W'(1);
                    instr_req_d = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_WB: begin
                rf_we       = 1'b1;
                rf_waddr    = (ir_q[7:6] == OP_LOAD) ? ir_q[3:2] : ir_q[1:0];
                rf_wdata    = (ir_q[7:6] == OP_LOAD) ? mdr_q : alu_q;
                pc_d        = pc_q + PC_W'(1);
                instr_req_d = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            alu_q       <= '0;
            mdr_q       <= '0;
            flags_q     <= '0;
            instr_req_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            lo_hex_q    <= SEG_ZERO;
            hi_hex_q    <= SEG_ZERO;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            alu_q       <= alu_d;
            mdr_q       <= mdr_d;
            flags_q     <= flags_d;
            instr_req_q <= instr_req_d;
            wb_valid_q  <= rf_we;
            if (rf_we) begin
                wb_data_q <= rf_wdata;
                lo_hex_q  <= seg7(rf_wdata[3:0]);
                hi_hex_q  <= seg7(rf_wdata[7:4]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= DMEM_INIT[i*DATA_W +: DATA_W];
        end else begin
            if (rf_we) regs_q[rf_waddr] <= rf_wdata;
            if (dm_we) dmem_q[dm_addr] <= opb_q;
        end
    end

    assign imem.instr_req = instr_req_q;
    assign imem.pc        = pc_q;
    assign wb_valid       = wb_valid_q;
    assign wb_data        = wb_data_q;
    assign lowerHex       = lo_hex_q;
    assign higherHex      = hi_hex_q;
    assign flags          = flags_q;
    assign halted         = (state_q == S_HALT);
endmodule

// File: tb/tb_multicycle_microprocessor.sv
// Bench for multicycle_microprocessor: directed program, writebacks checked by a scoreboard monitor.
// DMEM preload: [15]=0x05, [5]=0x7F, [6]=0x01.
module tb_multicycle_microprocessor;
    localparam int DATA_W = 8, PC_W = 8, DMEM_DEPTH = 16;
    localparam logic [127:0] INIT = (128'h05 << 120) | (128'h7F << 40) | (128'h01 << 48);
    localparam logic [6:0] H0 = 7'b1000000;

    logic clk = 1'b0;
    logic reset;
    logic wb_valid, halted;
    logic [DATA_W-1:0] wb_data;
    logic [6:0] lowerHex, higherHex;
    logic [1:0] flags;

    always #5 clk = ~clk;

    multicycle_microprocessor_if #(.PC_W(PC_W)) bus ();

    multicycle_microprocessor #(
        .DATA_W(DATA_W), .PC_W(PC_W), .DMEM_DEPTH(DMEM_DEPTH), .DMEM_INIT(INIT)
    ) dut (
        .clk(clk), .reset(reset), .imem(bus),
        .wb_valid(wb_valid), .wb_data(wb_data), .lowerHex(lowerHex),
        .higherHex(higherHex), .flags(flags), .halted(halted)
    );

    typedef struct {
        logic [7:0] data;
        logic [6:0] lo;
        logic [6:0] hi;
    } wb_t;

    wb_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input logic [7:0] d, input logic [6:0] lo, input logic [6:0] hi);
        wb_t e;
        e.data = d; e.lo = lo; e.hi = hi;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every writeback pulse must match the next queued expectation.
    always @(negedge clk) begin
        wb_t e;
        if (wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got wb_data %0h expected no writeback", wb_data);
            end else begin
                e = sb.pop_front();
                check("wb_data", wb_data, e.data);
                check("wb_lowerHex", lowerHex, e.lo);
                check("wb_higherHex", higherHex, e.hi);
            end
        end
    end

    task automatic wait_req(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.instr_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_req_timeout: got instr_req %b expected 1", name, bus.instr_req);
        end
    endtask

    task automatic issue(input logic [7:0] ins, input string name, output bit ok);
        wait_req(name, ok);
        if (ok) begin
            bus.instruction = ins;
            bus.instr_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("%s_req_drop", name), bus.instr_req, 1'b0);
            bus.instr_valid = 1'b0;
        end
    endtask

    task automatic run_instr(input logic [7:0] ins, input int lat, input logic [7:0] npc, input string name);
        bit ok;
        int n;
        issue(ins, name, ok);
        if (ok) begin
            n = 0;
            while (n < 20) begin
                @(posedge clk);
                n++;
                #1;
                if (bus.instr_req === 1'b1) break;
            end
            check($sformatf("%s_latency", name), n, lat);
            check($sformatf("%s_pc", name), bus.pc, npc);
            check($sformatf("%s_halted", name), halted, 1'b0);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check($sformatf("%s_pc", name), bus.pc, 0);
        check($sformatf("%s_req", name), bus.instr_req, 0);
        check($sformatf("%s_wb_valid", name), wb_valid, 0);
        check($sformatf("%s_wb_data", name), wb_data, 0);
        check($sformatf("%s_flags", name), flags, 0);
        check($sformatf("%s_halted", name), halted, 0);
        check($sformatf("%s_lowerHex", name), lowerHex, H0);
        check($sformatf("%s_higherHex", name), higherHex, H0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit seen;
        logic [7:0] halt_pc;
        logic [1:0] halt_flags;

        reset = 1'b0;
        bus.instruction = 8'h00;
        bus.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("req_first_edge", bus.instr_req, 1'b1);

        expect_wb(8'h00, H0, H0);
        run_instr(8'h40, 4, 8'd1, "load_r0");
        expect_wb(8'h00, H0, H0);
        run_instr(8'h1B, 3, 8'd2, "add_zero");

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_req", bus.instr_req, 1'b1);
            check("stall_pc", bus.pc, 8'd2);
        end

        expect_wb(8'h05, 7'b0010010, H0);
        run_instr(8'h47, 4, 8'd3, "load_r1");
        run_instr(8'h85, 3, 8'd4, "store");
        expect_wb(8'h05, 7'b0010010, H0);
        run_instr(8'h49, 4, 8'd5, "load_r2");
        run_instr(8'hDB, 2, 8'd4, "beq_taken");
        run_instr(8'hC7, 2, 8'd5, "beq_not_taken");
        expect_wb(8'h0A, 7'b0001000, H0);
        run_instr(8'h1B, 3, 8'd6, "add_ten");
        expect_wb(8'h7F, 7'b0001110, 7'b1111000);
        run_instr(8'h58, 4, 8'd7, "load_7f");
        expect_wb(8'h01, 7'b1111001, H0);
        run_instr(8'h5D, 4, 8'd8, "load_01");

`ifdef MP_OVF_TRAP_EN
        halt_pc    = 8'd8;
        halt_flags = 2'b10;
        issue(8'h2C, "add_ovf_trap", ok);
`else
        expect_wb(8'h80, H0, 7'b0000000);
        run_instr(8'h2C, 3, 8'd9, "add_ovf");
        check("ovf_flags", flags, 2'b10);
        halt_pc    = 8'd9;
        halt_flags = 2'b11;
        issue(8'hD4, "beq_self", ok);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("halt_halted", halted, 1'b1);
        check("halt_flags", flags, halt_flags);
        check("halt_pc", bus.pc, halt_pc);
        seen = 1'b0;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen = seen | bus.instr_req;
        end
        bus.instr_valid = 1'b0;
        check("halt_req_quiet", seen, 1'b0);
        check("halt_pc_hold", bus.pc, halt_pc);
        check("sb_drained", sb.size(), 0);

        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        issue(8'h47, "rst_load", ok);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        reset = 1'b1;
        expect_wb(8'h00, H0, H0);
        run_instr(8'h13, 3, 8'd1, "post_reset_add");

        repeat (2) @(negedge clk);
        check("sb_final", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
